matrix_argmax_unit: RTL and testbench

- Upstream producer for the argmax result memory.
- Consumes a stream of signed dot-product results, row-major, WEIGHT_COLS values per feature row.
- Tracks the running maximum per row and, once a row completes, issues one write of the winning column index to the memory write port (write_row, wr_en, data).
- Sequences FEATURE_ROWS rows per job, then pulses done.

---
 rtl/matrix_argmax_unit_pkg.sv | 21 ++
 rtl/matrix_argmax_unit_if.sv | 44 ++++
 rtl/matrix_argmax_unit.sv | 103 ++++++++++
 tb/tb_matrix_argmax_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_argmax_unit_pkg.sv
// Shared types and default sizes for the argmax producer and its memory.
// Holds the FSM state enum and a helper for index widths.
package matrix_pkg;

  localparam int FEATURE_ROWS_DEF   = 6;
  localparam int WEIGHT_COLS_DEF    = 3;
  localparam int DOT_PROD_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE,
    DONE
  } argmax_state_t;

  // Index width that never collapses to zero for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_argmax_unit_if.sv
// Handshake and memory-write bundle of the argmax unit.
// master: job/stream source (drives start, dot_valid, dot_prod_in);
// slave: argmax unit (drives dot_ready, wr_en, write_row, data, busy, done).
interface matrix_argmax_unit_if #(
  parameter int DW = 16,
  parameter int FW = 3,
  parameter int WW = 2
);

  logic                 start;
  logic                 dot_valid;
  logic signed [DW-1:0] dot_prod_in;
  logic                 dot_ready;
  logic                 wr_en;
  logic [FW-1:0]        write_row;
  logic [WW-1:0]        fm_wm_adj_row_out;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output dot_valid,
    output dot_prod_in,
    input  dot_ready,
    input  wr_en,
    input  write_row,
    input  fm_wm_adj_row_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  dot_valid,
    input  dot_prod_in,
    output dot_ready,
    output wr_en,
    output write_row,
    output fm_wm_adj_row_out,
    output busy,
    output done
  );

endinterface

// File: rtl/matrix_argmax_unit.sv
// Row-wise argmax over a signed dot-product stream; one memory write per row.
// Ports: clk, rst (async active-low), arg_if (slave side of the bundle).
module matrix_argmax_unit
  import matrix_pkg::*;
#(
  parameter int FEATURE_ROWS   = FEATURE_ROWS_DEF,
  parameter int WEIGHT_COLS    = WEIGHT_COLS_DEF,
  parameter int DOT_PROD_WIDTH = DOT_PROD_WIDTH_DEF,
  parameter int WEIGHT_WIDTH   = idx_w(WEIGHT_COLS),
  parameter int FEATURE_WIDTH  = idx_w(FEATURE_ROWS)
) (
  input logic clk,
  input logic rst,
  matrix_argmax_unit_if.slave arg_if
);

  localparam logic [WEIGHT_WIDTH-1:0] COL_LAST =
    WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [FEATURE_WIDTH-1:0] ROW_LAST =
    FEATURE_WIDTH'(FEATURE_ROWS - 1);

  argmax_state_t                     state_q;
  logic [FEATURE_WIDTH-1:0]          row_q;
  logic [WEIGHT_WIDTH-1:0]           col_q;
  logic [WEIGHT_WIDTH-1:0]           idx_q;
  logic signed [DOT_PROD_WIDTH-1:0]  max_q;
  logic [FEATURE_WIDTH-1:0]          wr_row_q;
  logic [WEIGHT_WIDTH-1:0]           wr_idx_q;

  logic                              accept;
  logic                              take;
  logic [WEIGHT_WIDTH-1:0]           idx_d;
  logic signed [DOT_PROD_WIDTH-1:0]  max_d;

  // First beat of a row always loads; later beats need strictly greater,
  // so ties keep the lowest column.
  always_comb begin
    accept = (state_q == ACCUM) && arg_if.dot_valid;
    take   = (col_q == '0) ||
             ($signed(arg_if.dot_prod_in) > max_q);
    max_d  = take ? arg_if.dot_prod_in : max_q;
    idx_d  = take ? col_q : idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      idx_q    <= '0;
      max_q    <= '0;
      wr_row_q <= '0;
      wr_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arg_if.start) begin
            row_q   <= '0;
            col_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            max_q <= max_d;
            idx_q <= idx_d;
            if (col_q == COL_LAST) begin
              col_q    <= '0;
              // Output regs load here so they hold between writes.
              wr_row_q <= row_q;
              wr_idx_q <= idx_d;
              state_q  <= WRITE;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (row_q == ROW_LAST) begin
            state_q <= DONE;
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= ACCUM;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arg_if.dot_ready         = (state_q == ACCUM);
  assign arg_if.wr_en             = (state_q == WRITE);
  assign arg_if.busy              = (state_q != IDLE);
  assign arg_if.done              = (state_q == DONE);
  assign arg_if.write_row         = wr_row_q;
  assign arg_if.fm_wm_adj_row_out = wr_idx_q;

endmodule

// File: tb/tb_matrix_argmax_unit.sv
// Self-checking bench for matrix_argmax_unit.
// Random streams checked cycle by cycle against a row/beat reference model.
module tb_matrix_argmax_unit;
  import matrix_pkg::*;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int DW   = 16;
  localparam int FW   = 3;
  localparam int WW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_argmax_unit_if #(.DW(DW), .FW(FW), .WW(WW)) bus ();

  matrix_argmax_unit #(
    .FEATURE_ROWS(ROWS),
    .WEIGHT_COLS(COLS),
    .DOT_PROD_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arg_if(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: what the outputs must look like this cycle.
  bit m_busy, m_ready, m_wr, m_done;
  int m_row, m_wrow, m_widx;
  int beats[$];
  int wr_cnt, done_cnt;
  bit lit_mode;
  int lit_q[$];

  function automatic int argmax(input int b[$]);
    int best = 0;
    for (int i = 1; i < b.size(); i++)
      if (b[i] > b[best]) best = i;
    return best;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_ready", bus.dot_ready, 0);
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_row", bus.write_row, 0);
      check("rst_idx", bus.fm_wm_adj_row_out, 0);
      m_busy = 0; m_ready = 0; m_wr = 0; m_done = 0;
      m_row = 0; m_wrow = 0; m_widx = 0;
      beats.delete();
    end else begin
      check("dot_ready", bus.dot_ready, m_ready);
      check("wr_en", bus.wr_en, m_wr);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("write_row", bus.write_row, m_wrow);
      check("argmax_idx", bus.fm_wm_adj_row_out, m_widx);
      if (bus.wr_en) wr_cnt++;
      if (bus.done) done_cnt++;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_wr) begin
        m_wr = 0;
        if (m_row == ROWS - 1) m_done = 1;
        else begin
          m_row++;
          m_ready = 1;
        end
      end else if (m_ready) begin
        if (bus.dot_valid) begin
          beats.push_back(int'($signed(bus.dot_prod_in)));
          if (beats.size() == COLS) begin
            m_widx  = argmax(beats);
            m_wrow  = m_row;
            m_wr    = 1;
            m_ready = 0;
            beats.delete();
            if (lit_mode && lit_q.size() > 0)
              check("model_pin", m_widx, lit_q.pop_front());
          end
        end
      end else if (bus.start) begin
        m_busy  = 1;
        m_ready = 1;
        m_row   = 0;
        beats.delete();
      end
    end
  end

  int vals[$];

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
      1: return 16'($urandom_range(0, 2));
      default: return 16'($urandom);
    endcase
  endfunction

  // mode 0: directed values, valid held; 1: random; 2: random plus
  // stray starts; 3: random, reset at row 3 col 1.
  task automatic run_job(input int mode, output int wrs, output int dns,
                         output int lat);
    int  k = 0;
    int  negs = 0;
    bit  acc;
    bit  fin = 0;
    wr_cnt = 0;
    done_cnt = 0;
    lat = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.dot_valid = 1'b1;
    bus.dot_prod_in = (mode == 0) ? 16'(vals[0]) : rnd_val();
    forever begin
      @(negedge clk); #1;
      negs++;
      acc = bus.dot_valid && bus.dot_ready;
      if (bus.done) begin
        fin = 1;
        lat = negs - 1;
      end
      @(posedge clk); #1;
      bus.start = (mode == 2 && bus.busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (acc) k++;
      if (mode == 3 && k == 10) begin
        rst = 1'b0;
        bus.dot_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        break;
      end
      if (mode == 0) begin
        bus.dot_valid = 1'b1;
        bus.dot_prod_in = (k < vals.size()) ? 16'(vals[k]) : '0;
      end else begin
        bus.dot_valid = $urandom_range(0, 1);
        bus.dot_prod_in = rnd_val();
      end
      if (fin) break;
      if (negs > 400) begin
        check("job_timeout", 1, 0);
        break;
      end
    end
    bus.start = 1'b0;
    bus.dot_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    wrs = wr_cnt;
    dns = done_cnt;
  endtask

  int w, d, l;

  initial begin
    bus.start = 1'b0;
    bus.dot_valid = 1'b0;
    bus.dot_prod_in = '0;
    lit_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    vals = '{5, 9, 2, 7, 7, 3, 3, 7, 7,
             'hFFFD, 'hFFFF, 'hFFF8, 'h8000, 'h7FFF, 0, 1, 1, 1};
    lit_q = '{1, 0, 1, 1, 1, 0};
    lit_mode = 1;
    run_job(0, w, d, l);
    lit_mode = 0;
    check("dir_writes", w, 6);
    check("dir_done", d, 1);
    check("dir_latency", l, ROWS * (COLS + 1) + 1);
    check("dir_pins_used", lit_q.size(), 0);

    for (int j = 0; j < 3; j++) begin
      run_job(1, w, d, l);
      check("rnd_writes", w, 6);
      check("rnd_done", d, 1);
    end
    for (int j = 0; j < 2; j++) begin
      run_job(2, w, d, l);
      check("stray_start_writes", w, 6);
      check("stray_start_done", d, 1);
    end
    run_job(3, w, d, l);
    check("abort_writes", w, 3);
    check("abort_done", d, 0);
    run_job(1, w, d, l);
    check("restart_writes", w, 6);
    check("restart_done", d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
